// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 scan-code receiver.
// Optional build macro PS2_PARITY_CHECK_EN enables the odd-parity check.
package ps2_pkg;

  // Device-to-host frame: start, d0..d7, parity, stop
  localparam int FRAME_BITS = 11;

  // Common scan codes, for consumers of the queued bytes
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXTEND = 8'hE0;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;

  // Odd parity holds when the data bits and the parity bit XOR to 1
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Synchroniser for the raw PS/2 pins plus the ps2_clk falling-edge strobe.
// Stage 0 is nearest the pin; the edge is seen when the oldest stage still
// holds 1 while the stage before it already holds 0.
module ps2_sync_edge
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 3
) (
  input  logic clk,
  input  logic srst_i,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic fall_o,
  output logic data_o
);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;

  // Shift both pins through their synchroniser chains; idle bus level is 1
  always_ff @(posedge clk) begin
    if (srst_i) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
    end
  end

  // Data is taken from the same stage that first shows the low clock level
  assign fall_o = clk_sync_q[SYNC_STAGES-1] & ~clk_sync_q[SYNC_STAGES-2];
  assign data_o = data_sync_q[SYNC_STAGES-2];

endmodule

// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard receiver: deframes 11-bit frames and queues scan bytes in a
// small FIFO read through a ready / nextdata_n handshake.
// Build macro PS2_PARITY_CHECK_EN: when defined, frames with bad odd parity
// are dropped; otherwise only start and stop bits are checked.
module ps2_scan_receiver
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 3
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

  logic fall;
  logic sdata;

  ps2_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .srst_i    (clrn),
    .ps2_clk_i (ps2_clk),
    .ps2_data_i(ps2_data),
    .fall_o    (fall),
    .data_o    (sdata)
  );

  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [9:0]    shift_q, shift_d;
  logic          frame_done;
  logic          frame_ok;
  logic [7:0]    rx_byte;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic          empty, full, push_req, push, pop;

  // Deframer: bits 0..9 shift in MSB-first so the start bit ends up in
  // shift_q[0]; the 11th edge (stop bit) completes the frame directly
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    frame_done = 1'b0;
    rx_byte    = shift_q[8:1];
    frame_ok   = ~shift_q[0] & sdata;
`ifdef PS2_PARITY_CHECK_EN
    frame_ok   = frame_ok & odd_parity_ok(shift_q[8:1], shift_q[9]);
`endif
    if (fall) begin
      if (bit_cnt_q == LAST_BIT) begin
        frame_done = 1'b1;
        bit_cnt_d  = '0;
        shift_d    = '0;
      end else begin
        shift_d    = {sdata, shift_q[9:1]};
        bit_cnt_d  = bit_cnt_q + 4'd1;
      end
    end
  end

  // FIFO control: a pop frees the slot a full-FIFO push needs on the same edge
  always_comb begin
    empty      = (wr_ptr_q == rd_ptr_q);
    full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop        = ~empty & ~nextdata_n;
    push_req   = frame_done & frame_ok;
    push       = push_req & (~full | pop);
    overflow_d = overflow_q | (push_req & full & ~pop);
    wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop};
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (clrn) begin
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Byte storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= rx_byte;
    end
  end

  assign ready    = ~empty;
  assign data     = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
  assign overflow = overflow_q;

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Self-checking bench for ps2_scan_receiver with a scoreboard queue of
// expected bytes; honours PS2_PARITY_CHECK_EN when defined.
module tb_ps2_scan_receiver;

  localparam int SYNC     = 3;
  localparam int DEPTH    = 8;
  localparam int HALF_BIT = 15;   // clk cycles per ps2_clk half period
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clrn = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       nextdata_n = 1'b1;
  logic [7:0] data;
  logic       ready;
  logic       overflow;

  int unsigned exp_q[$];
  bit          ovf_exp = 1'b0;
  int          assert_cnt = 0;
  int          fail_cnt = 0;

  always #10 clk = ~clk;

  ps2_scan_receiver #(
    .FIFO_DEPTH (DEPTH),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk       (clk),
    .clrn      (clrn),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .nextdata_n(nextdata_n),
    .data      (data),
    .ready     (ready),
    .overflow  (overflow)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assert_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Check FIFO-visible state against the model
  task automatic check_state(input string tag);
    check_eq({tag, "_ready"}, {31'd0, ready}, {31'd0, exp_q.size() != 0});
    check_eq({tag, "_ovf"}, {31'd0, overflow}, {31'd0, ovf_exp});
    if (exp_q.size() != 0)
      check_eq({tag, "_head"}, {24'd0, data}, exp_q[0]);
  endtask

  // Drive one frame; optionally pop on the exact completion cycle
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit pop_at_end);
    logic [10:0] frame;
    bit          par;
    int          used;
    par   = ~(^b) ^ bad_par;
    frame = {1'b1, par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2_data = frame[i];
      wait_cycles(HALF_BIT);
      ps2_clk = 1'b0;
      used = 0;
      if (i == 10) begin
        if (pop_at_end) begin
          wait_cycles(SYNC - 1);
          check_eq("simul_head", {24'd0, data}, exp_q[0]);
          nextdata_n = 1'b0;
          wait_cycles(1);
          nextdata_n = 1'b1;
          void'(exp_q.pop_front());
          used = SYNC;
        end
        if (!(PAR_EN && bad_par)) begin
          if (exp_q.size() < DEPTH) exp_q.push_back({24'd0, b});
          else ovf_exp = 1'b1;
        end
        wait_cycles(SYNC + 2 - used);
        used = SYNC + 2;
        $display("frame %02h bad_par=%0d pop=%0d -> ready=%0d data=%02h ovf=%0d",
                 b, bad_par, pop_at_end, ready, data, overflow);
        check_state($sformatf("frame_%02h", b));
      end
      wait_cycles(HALF_BIT - used);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    wait_cycles(HALF_BIT);
  endtask

  task automatic pop_one();
    if (exp_q.size() == 0) begin
      check_eq("pop_empty_ready", {31'd0, ready}, 32'd0);
    end else begin
      $display("pop data=%02h expected=%02h", data, exp_q[0]);
      check_eq("pop_ready", {31'd0, ready}, 32'd1);
      check_eq("pop_data", {24'd0, data}, exp_q.pop_front());
    end
    nextdata_n = 1'b0;
    wait_cycles(1);
    nextdata_n = 1'b1;
    wait_cycles(1);
  endtask

  task automatic drain();
    while (exp_q.size() != 0) pop_one();
    check_eq("drain_ready", {31'd0, ready}, 32'd0);
  endtask

  initial begin
    wait_cycles(4);
    clrn = 1'b0;
    wait_cycles(2);
    $display("reset ready=%0d data=%02h ovf=%0d", ready, data, overflow);
    check_eq("reset_ready", {31'd0, ready}, 32'd0);
    check_eq("reset_data", {24'd0, data}, 32'h00);
    check_eq("reset_ovf", {31'd0, overflow}, 32'd0);

    // Single byte
    send_frame(8'h1C, 1'b0, 1'b0);
    drain();

    // Two bytes, popped in order
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    pop_one();
    check_state("after_pop1");
    pop_one();
    check_state("after_pop2");

    // Bad parity: dropped only when the check is built in
    send_frame(8'h1C, 1'b1, 1'b0);
    drain();

    // Overflow: nine frames without popping
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0);
    check_eq("ovf_set", {31'd0, overflow}, 32'd1);
    drain();
    check_eq("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Reset in the middle of a frame
    ps2_data = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_cycles(HALF_BIT);
      ps2_clk = 1'b0;
      wait_cycles(HALF_BIT);
      ps2_clk = 1'b1;
    end
    clrn = 1'b1;
    wait_cycles(1);
    clrn = 1'b0;
    exp_q.delete();
    ovf_exp = 1'b0;
    ps2_data = 1'b1;
    wait_cycles(HALF_BIT);
    send_frame(8'h58, 1'b0, 1'b0);
    check_eq("midreset_ovf", {31'd0, overflow}, 32'd0);
    drain();

    // Full FIFO with a pop on the completion cycle of the ninth frame
    for (int i = 0; i < 8; i++) send_frame(8'(8'h10 + i), 1'b0, 1'b0);
    send_frame(8'h18, 1'b0, 1'b1);
    check_eq("simul_ovf", {31'd0, overflow}, 32'd0);
    check_eq("simul_occ", exp_q.size(), 32'd8);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
